halfword_narrow_tx: RTL and testbench

- Transmit-side counterpart of the 16→32 immediate/data sign extension: narrows 32-bit words onto a 16-bit halfword stream.
- When the upper 16 bits are exactly the sign-extension of bit 15, the word is sent as one flagged halfword; the receiver re-extends it. Otherwise the word is sent as two halfwords, low half first.
- Sits between the core's 32-bit store/writeback data path and the 16-bit memory/link bus.
- Valid/ready handshake on both sides.

---
 rtl/narrow_defs.sv | 16 +
 rtl/sext_detect.sv | 15 +
 rtl/halfword_narrow_tx.sv | 141 ++++++++++++++
 tb/tb_halfword_narrow_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/narrow_defs.sv
// Shared constants for the 32->16 narrowing transmitter and its receive-side
// counterpart: bus widths and the beat-sequencer state encoding.
package narrow_defs;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  // Beat sequencer states: IDLE waits for a word, LO presents the low (or only)
  // halfword, HI presents the upper halfword of an uncompressed word.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

endpackage

// File: rtl/sext_detect.sv
// Reports whether a 32-bit word is the sign extension of its low halfword,
// i.e. whether it can travel as a single halfword and be re-extended later.
module sext_detect
  import narrow_defs::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic              o_sext
);

  // Upper half must replicate bit 15 exactly.
  always_comb begin
    o_sext = (i_word[WORD_W-1:HALF_W] == {HALF_W{i_word[HALF_W-1]}});
  end

endmodule

// File: rtl/halfword_narrow_tx.sv
// Narrows 32-bit words onto a 16-bit halfword stream. Sign-extendable words
// go out as one beat flagged with out_ext (when COMPRESS=1); all other words
// go out as two beats, low half first.
//
// Handshake: on each side a transfer happens on a cycle where valid and ready
// are both high; valid never depends on ready, and once out_valid is raised
// out_data/out_last/out_ext hold until the beat is taken.
//
// Optional macro HWNT_STATS_EN adds saturating counters stat_words/stat_comp.
module halfword_narrow_tx
  import narrow_defs::*;
#(
  parameter bit COMPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_data,
  output logic              out_last,
  output logic              out_ext,
`ifdef HWNT_STATS_EN
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_comp,
`endif
  output logic [1:0]        dbg_state
);

  state_t              r_state;
  logic [WORD_W-1:0]   r_word;
  logic [HALF_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_out_ext;

  state_t              w_nxt_state;
  logic [WORD_W-1:0]   w_nxt_word;
  logic [HALF_W-1:0]   w_nxt_data;
  logic                w_nxt_last;
  logic                w_nxt_ext;
  logic                w_sext;
  logic                w_beat_done;
  logic                w_word_done;
  logic                w_accept;
  logic                w_single;

  sext_detect u_sext_detect (
    .i_word (in_data),
    .o_sext (w_sext)
  );

  // Handshake decode; a new word may enter on the cycle the current one finishes.
  always_comb begin
    out_valid   = (r_state != IDLE);
    w_beat_done = out_valid & out_ready;
    w_word_done = w_beat_done & r_out_last;
    in_ready    = (r_state == IDLE) | w_word_done;
    w_accept    = in_valid & in_ready;
    w_single    = w_sext & COMPRESS;
    out_data    = r_out_data;
    out_last    = r_out_last;
    out_ext     = r_out_ext;
    dbg_state   = r_state;
  end

  // Next-state and next-beat selection; an accept always loads the LO beat.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_word  = r_word;
    w_nxt_data  = r_out_data;
    w_nxt_last  = r_out_last;
    w_nxt_ext   = r_out_ext;
    if (w_accept) begin
      w_nxt_state = LO;
      w_nxt_word  = in_data;
      w_nxt_data  = in_data[HALF_W-1:0];
      w_nxt_last  = w_single;
      w_nxt_ext   = w_single;
    end else begin
      case (r_state)
        LO: begin
          if (w_beat_done) begin
            if (r_out_last) begin
              w_nxt_state = IDLE;
            end else begin
              w_nxt_state = HI;
              w_nxt_data  = r_word[WORD_W-1:HALF_W];
              w_nxt_last  = 1'b1;
              w_nxt_ext   = 1'b0;
            end
          end
        end
        HI: begin
          if (w_beat_done) begin
            w_nxt_state = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, held word and beat output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_out_ext  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_word     <= w_nxt_word;
      r_out_data <= w_nxt_data;
      r_out_last <= w_nxt_last;
      r_out_ext  <= w_nxt_ext;
    end
  end

`ifdef HWNT_STATS_EN
  logic [15:0] r_stat_words;
  logic [15:0] r_stat_comp;

  // Saturating completion counters, stepped on each word's final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_words <= '0;
      r_stat_comp  <= '0;
    end else if (w_word_done) begin
      if (r_stat_words != 16'hFFFF) r_stat_words <= r_stat_words + 16'd1;
      if (r_out_ext && (r_stat_comp != 16'hFFFF)) r_stat_comp <= r_stat_comp + 16'd1;
    end
  end

  assign stat_words = r_stat_words;
  assign stat_comp  = r_stat_comp;
`endif

endmodule

// File: tb/tb_halfword_narrow_tx.sv
// Bench for halfword_narrow_tx: one instance with COMPRESS=1 (a_*) and one with
// COMPRESS=0 (b_*). Drivers push expected beats at accept time; negedge
// monitors pop and compare every completed beat.
module tb_halfword_narrow_tx;

  logic        clk;
  logic        rst;
  int          cyc;
  int          check_cnt;
  int          pass_cnt;
  bit          rand_en;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_out_ext;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_dbg_state;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_ext;
  logic [31:0] b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_dbg_state;
`ifdef HWNT_STATS_EN
  logic [15:0] a_stat_words, a_stat_comp, b_stat_words, b_stat_comp;
`endif

  // expected beat = {data[15:0], last, ext}
  logic [17:0] a_exp_q[$];
  logic [17:0] b_exp_q[$];
  int          a_beats, b_beats, a_last_beat_cyc, a_acc_cyc;
  int          a_mdl_words, a_mdl_comp, b_mdl_words, b_mdl_comp;
  bit          a_hold_v, b_hold_v;
  logic [18:0] a_hold, b_hold;

  halfword_narrow_tx #(.COMPRESS(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_ext(a_out_ext),
`ifdef HWNT_STATS_EN
    .stat_words(a_stat_words), .stat_comp(a_stat_comp),
`endif
    .dbg_state(a_dbg_state)
  );

  halfword_narrow_tx #(.COMPRESS(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_ext(b_out_ext),
`ifdef HWNT_STATS_EN
    .stat_words(b_stat_words), .stat_comp(b_stat_comp),
`endif
    .dbg_state(b_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // Random downstream backpressure while enabled; changes just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (rand_en) begin
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model ----------------
  // A word fits a halfword when its signed value lies in the 16-bit signed range.
  function automatic int model_beats(input logic [31:0] w, input bit compress,
                                     output logic [17:0] b0, output logic [17:0] b1);
    int signed sw;
    bit        fits;
    sw   = $signed(w);
    fits = (sw >= -32768) && (sw <= 32767);
    b1   = '0;
    if (fits && compress) begin
      b0 = {w[15:0], 1'b1, 1'b1};
      return 1;
    end
    b0 = {w[15:0], 1'b0, 1'b0};
    b1 = {w[31:16], 1'b1, 1'b0};
    return 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- drivers ----------------
  task automatic send_a(input logic [31:0] w);
    bit acc;
    int n;
    logic [17:0] b0, b1;
    int nb;
    a_in_valid = 1'b1;
    a_in_data  = w;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    a_in_valid = 1'b0;
    a_in_data  = $urandom;
    if (!acc) begin
      check_cnt++;
      $display("FAIL a_accept_timeout: word %h not accepted, need accept", w);
    end else begin
      a_acc_cyc = cyc;
      nb = model_beats(w, 1'b1, b0, b1);
      a_exp_q.push_back(b0);
      if (nb == 2) a_exp_q.push_back(b1);
    end
  endtask

  task automatic send_b(input logic [31:0] w);
    bit acc;
    int n;
    logic [17:0] b0, b1;
    int nb;
    b_in_valid = 1'b1;
    b_in_data  = w;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    b_in_valid = 1'b0;
    b_in_data  = $urandom;
    if (!acc) begin
      check_cnt++;
      $display("FAIL b_accept_timeout: word %h not accepted, need accept", w);
    end else begin
      nb = model_beats(w, 1'b0, b0, b1);
      b_exp_q.push_back(b0);
      if (nb == 2) b_exp_q.push_back(b1);
    end
  endtask

  task automatic wait_a_beats(input int target);
    int n;
    n = 0;
    while (a_beats < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (a_beats < target) begin
      check_cnt++;
      $display("FAIL a_beat_timeout: beats %0d, expected %0d", a_beats, target);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 3))
      0: return {{16{r[15]}}, r};
      1: return {16'h0000, r};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      a_hold_v = 1'b0;
    end else begin
      if (a_hold_v) chk("a_stall_hold", {13'd0, a_out_valid, a_out_last, a_out_ext, a_out_data}, {13'd0, a_hold});
      if (a_out_valid && a_out_ready) begin
        if (a_exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL a_unexpected_beat: got data %h last %b ext %b, expected no beat", a_out_data, a_out_last, a_out_ext);
        end else begin
          e = a_exp_q.pop_front();
          chk("a_beat", {14'd0, a_out_data, a_out_last, a_out_ext}, {14'd0, e});
          if (e[1]) begin
            a_mdl_words++;
            if (e[0]) a_mdl_comp++;
          end
        end
        a_beats++;
        a_last_beat_cyc = cyc;
      end
      a_hold_v = a_out_valid && !a_out_ready;
      a_hold   = {1'b1, a_out_last, a_out_ext, a_out_data};
    end
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      b_hold_v = 1'b0;
    end else begin
      if (b_hold_v) chk("b_stall_hold", {13'd0, b_out_valid, b_out_last, b_out_ext, b_out_data}, {13'd0, b_hold});
      if (b_out_valid && b_out_ready) begin
        if (b_exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL b_unexpected_beat: got data %h last %b ext %b, expected no beat", b_out_data, b_out_last, b_out_ext);
        end else begin
          e = b_exp_q.pop_front();
          chk("b_beat", {14'd0, b_out_data, b_out_last, b_out_ext}, {14'd0, e});
          if (e[1]) begin
            b_mdl_words++;
            if (e[0]) b_mdl_comp++;
          end
        end
        b_beats++;
      end
      b_hold_v = b_out_valid && !b_out_ready;
      b_hold   = {1'b1, b_out_last, b_out_ext, b_out_data};
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    int n;
    cyc = 0; check_cnt = 0; pass_cnt = 0; rand_en = 1'b0;
    a_beats = 0; b_beats = 0; a_last_beat_cyc = 0; a_acc_cyc = 0;
    a_mdl_words = 0; a_mdl_comp = 0; b_mdl_words = 0; b_mdl_comp = 0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_out_regs", {14'd0, a_out_data, a_out_last, a_out_ext}, 32'd0);
    chk("rst_state", {30'd0, a_dbg_state}, 32'd0);
    chk("rst_b_state", {30'd0, b_dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // compressible word: one flagged beat, presented the cycle after accept
    a_out_ready = 1'b1;
    send_a(32'hFFFF8402);
    wait_a_beats(1);
    chk("lat_first_beat", a_last_beat_cyc, a_acc_cyc);

    // two-beat word; in_ready must be low while the low half is up
    send_a(32'h12345678);
    @(negedge clk);
    chk("lo_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("lo_out_valid", {31'd0, a_out_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_a_beats(3);

    // back-to-back mix: four beats in four consecutive cycles
    send_a(32'h00007FFF);
    c0 = a_acc_cyc;
    send_a(32'h00008000);
    send_a(32'hFFFFFFFF);
    wait_a_beats(7);
    chk("b2b_no_bubble", a_last_beat_cyc - c0, 32'd3);

    // boundary words under full throughput
    send_a(32'hFFFF8000);
    send_a(32'hFFFF7FFF);
    send_a(32'h00000000);
    wait_a_beats(11);

    // backpressure: first beat held stable for five stalled cycles
    a_out_ready = 1'b0;
    send_a(32'hABCD0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, a_out_valid}, 32'd1);
      chk("stall_data", {16'd0, a_out_data}, 32'h0001);
    end
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    wait_a_beats(13);

    // reset while the upper half of 0xDEAD0000 is pending
    send_a(32'hDEAD0000);
    @(posedge clk);
    #1;
    chk("pre_rst_hi_state", {30'd0, a_dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd1);
    a_exp_q.delete();
    b_exp_q.delete();
    a_mdl_words = 0; a_mdl_comp = 0; b_mdl_words = 0; b_mdl_comp = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {30'd0, a_out_valid, a_in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // COMPRESS=0 instance: always two unflagged beats
    b_out_ready = 1'b1;
    send_b(32'hFFFF8402);
    n = 0;
    while (b_beats < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_two_beats", b_beats, 32'd2);

    // randomized traffic with random backpressure on both instances
    rand_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          send_a(rand_word());
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 50; i++) begin
          send_b(rand_word());
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_a", a_exp_q.size(), 32'd0);
    chk("drain_b", b_exp_q.size(), 32'd0);
    rand_en = 1'b0;
    @(negedge clk);
`ifdef HWNT_STATS_EN
    chk("a_stat_words", {16'd0, a_stat_words}, a_mdl_words);
    chk("a_stat_comp", {16'd0, a_stat_comp}, a_mdl_comp);
    chk("b_stat_words", {16'd0, b_stat_words}, b_mdl_words);
    chk("b_stat_comp", {16'd0, b_stat_comp}, 32'd0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
